// File: rtl/dmem_responder_if.sv
// dmem_responder_if
//   Processor <-> data-memory command bus.
//   master modport: processor side (drives proc2mem_*, observes mem2proc_* / mem_error).
//   slave modport : memory side (observes proc2mem_*, drives mem2proc_* / mem_error).
//   proc2mem_command  2b  0 NONE, 1 LOAD, 2 STORE, 3 reserved
//   proc2mem_addr    32b  byte address
//   proc2mem_data    32b  store data, right-aligned
//   proc2mem_size     2b  0 byte, 1 half, 2 word, 3 reserved
//   mem2proc_response 4b  tag given to this cycle's request, 0 = not accepted
//   mem2proc_tag      4b  tag of the request completing this cycle, 0 = none
//   mem2proc_data    32b  load word of the completing request
//   mem_error         1b  pulse one cycle after a rejected request
interface dmem_responder_if;
    logic [1:0]  proc2mem_command;
    logic [31:0] proc2mem_addr;
    logic [31:0] proc2mem_data;
    logic [1:0]  proc2mem_size;
    logic [3:0]  mem2proc_response;
    logic [3:0]  mem2proc_tag;
    logic [31:0] mem2proc_data;
    logic        mem_error;

    modport master (
        output proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size,
        input  mem2proc_response, mem2proc_tag, mem2proc_data, mem_error
    );

    modport slave (
        input  proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size,
        output mem2proc_response, mem2proc_tag, mem2proc_data, mem_error
    );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder
//   Data-memory responder for the processor command bus. Stores are written
//   into a word array at their acceptance edge; loads snapshot the addressed
//   word at their acceptance edge. Every accepted request is tagged and
//   completes exactly LATENCY cycles later, in order, on mem2proc_tag/data.
// Parameters
//   ADDR_BITS  log2 of the number of 32-bit words (array indexed by addr[ADDR_BITS+1:2])
//   LATENCY    cycles from acceptance edge to completion, 1..15
// Ports
//   clk  rising-edge clock
//   rst  asynchronous active-high reset (array contents are kept)
//   bus  slave side of dmem_responder_if
module dmem_responder #(
    parameter int ADDR_BITS = 12,
    parameter int LATENCY   = 2
) (
    input  logic              clk,
    input  logic              rst,
    dmem_responder_if.slave   bus
);

    localparam int          WORDS     = 1 << ADDR_BITS;
    localparam logic [1:0]  BUS_NONE  = 2'h0;
    localparam logic [1:0]  BUS_LOAD  = 2'h1;
    localparam logic [1:0]  BUS_STORE = 2'h2;
    localparam logic [1:0]  SIZE_BYTE = 2'h0;
    localparam logic [1:0]  SIZE_HALF = 2'h1;
    localparam logic [1:0]  SIZE_WORD = 2'h2;

    logic [31:0]          mem_q [WORDS];

    logic [ADDR_BITS-1:0] word_idx;
    logic                 addr_in_range;
    logic                 aligned;
    logic                 cmd_valid;
    logic                 accept;
    logic                 do_store;
    logic [3:0]           byte_en;
    logic [31:0]          wdata;
    logic [31:0]          rd_word;

    logic [3:0]           tag_ctr_q, tag_ctr_d;
    logic                 mem_error_q, mem_error_d;

    // Each completion stage holds {tag, data}. A zero tag marks an empty
    // stage (tags are never 0) and store completions carry zero data, so the
    // valid and is_load bits are folded into these two fields.
    logic [3:0]           pipe_tag_q  [LATENCY];
    logic [3:0]           pipe_tag_d  [LATENCY];
    logic [31:0]          pipe_data_q [LATENCY];
    logic [31:0]          pipe_data_d [LATENCY];

    // Request decode and acceptance. Acceptance is suppressed while rst is
    // high so nothing is tagged or written during reset.
    always_comb begin
        word_idx      = bus.proc2mem_addr[ADDR_BITS+1:2];
        addr_in_range = (bus.proc2mem_addr[31:ADDR_BITS+2] == '0);
        cmd_valid     = (bus.proc2mem_command == BUS_LOAD) ||
                        (bus.proc2mem_command == BUS_STORE);
        case (bus.proc2mem_size)
            SIZE_BYTE: aligned = 1'b1;
            SIZE_HALF: aligned = ~bus.proc2mem_addr[0];
            SIZE_WORD: aligned = (bus.proc2mem_addr[1:0] == 2'b00);
            default:   aligned = 1'b0;
        endcase
        accept   = cmd_valid && addr_in_range && aligned && !rst;
        do_store = accept && (bus.proc2mem_command == BUS_STORE);
        rd_word  = mem_q[word_idx];
    end

    // Store lanes: the store data is replicated across the word so each
    // enabled lane simply takes its own byte of wdata.
    always_comb begin
        case (bus.proc2mem_size)
            SIZE_BYTE: begin
                byte_en = 4'b0001 << bus.proc2mem_addr[1:0];
                wdata   = {4{bus.proc2mem_data[7:0]}};
            end
            SIZE_HALF: begin
                byte_en = bus.proc2mem_addr[1] ? 4'b1100 : 4'b0011;
                wdata   = {2{bus.proc2mem_data[15:0]}};
            end
            default: begin
                byte_en = 4'b1111;
                wdata   = bus.proc2mem_data;
            end
        endcase
    end

    // Next-state for the tag counter, error pulse and completion pipeline.
    always_comb begin
        tag_ctr_d = tag_ctr_q;
        if (accept) begin
            tag_ctr_d = (tag_ctr_q == 4'd15) ? 4'd1 : tag_ctr_q + 4'd1;
        end

        mem_error_d = (bus.proc2mem_command != BUS_NONE) && !accept;

        pipe_tag_d[0]  = accept ? tag_ctr_q : 4'd0;
        pipe_data_d[0] = (accept && bus.proc2mem_command == BUS_LOAD) ? rd_word : 32'd0;
        for (int i = 1; i < LATENCY; i++) begin
            pipe_tag_d[i]  = pipe_tag_q[i-1];
            pipe_data_d[i] = pipe_data_q[i-1];
        end
    end

    // Word array: no reset, contents survive rst.
    always_ff @(posedge clk) begin
        if (do_store) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem_q[word_idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_ctr_q   <= 4'd1;
            mem_error_q <= 1'b0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_tag_q[i]  <= 4'd0;
                pipe_data_q[i] <= 32'd0;
            end
        end else begin
            tag_ctr_q   <= tag_ctr_d;
            mem_error_q <= mem_error_d;
            pipe_tag_q  <= pipe_tag_d;
            pipe_data_q <= pipe_data_d;
        end
    end

    assign bus.mem2proc_response = accept ? tag_ctr_q : 4'd0;
    assign bus.mem2proc_tag      = pipe_tag_q[LATENCY-1];
    assign bus.mem2proc_data     = pipe_data_q[LATENCY-1];
    assign bus.mem_error         = mem_error_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
//   Scoreboard bench for dmem_responder. Two instances share clk/rst: index 0
//   uses LATENCY=2, index 1 uses LATENCY=1. Expected completions and error
//   pulses are queued with the cycle they must appear in; a negedge monitor
//   compares every cycle, so a missing, late or spurious output is caught.
module tb_dmem_responder;

    localparam int ADDR_BITS = 12;
    localparam int D_L2 = 0;
    localparam int D_L1 = 1;
    localparam logic [1:0] NONE  = 2'h0;
    localparam logic [1:0] LOAD  = 2'h1;
    localparam logic [1:0] STORE = 2'h2;
    localparam logic [1:0] RSVD  = 2'h3;
    localparam logic [1:0] SZ_B  = 2'h0;
    localparam logic [1:0] SZ_H  = 2'h1;
    localparam logic [1:0] SZ_W  = 2'h2;

    typedef struct {
        int          due;
        logic [3:0]  tag;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_compared = 0;
    int   n_mismatched = 0;

    exp_t        exp_q [2][$];
    int          err_q [2][$];
    logic [31:0] model [int];
    logic [3:0]  tag_m [2];
    int          lat_m [2];

    dmem_responder_if bus2 ();
    dmem_responder_if bus1 ();

    dmem_responder #(.ADDR_BITS(ADDR_BITS), .LATENCY(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    dmem_responder #(.ADDR_BITS(ADDR_BITS), .LATENCY(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, wanted 0x%08h (cycle %0d)",
                     name, observed, expected, cyc);
        end
    endtask

    function automatic logic model_accept(input logic [1:0] cmd, input logic [31:0] addr,
                                          input logic [1:0] size);
        if (cmd != LOAD && cmd != STORE) return 1'b0;
        if (addr >= 32'(4 << ADDR_BITS)) return 1'b0;
        case (size)
            SZ_B:    return 1'b1;
            SZ_H:    return addr[0] == 1'b0;
            SZ_W:    return addr[1:0] == 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] data,
                                          input logic [31:0] addr, input logic [1:0] size);
        logic [31:0] w;
        w = old_w;
        case (size)
            SZ_B:    w[8*addr[1:0] +: 8]  = data[7:0];
            SZ_H:    w[16*addr[1] +: 16]  = data[15:0];
            default: w = data;
        endcase
        return w;
    endfunction

    task automatic set_bus(input int d, input logic [1:0] cmd, input logic [31:0] addr,
                           input logic [31:0] data, input logic [1:0] size);
        bus2.proc2mem_command = (d == D_L2) ? cmd : NONE;
        bus1.proc2mem_command = (d == D_L1) ? cmd : NONE;
        bus2.proc2mem_addr = addr;  bus1.proc2mem_addr = addr;
        bus2.proc2mem_data = data;  bus1.proc2mem_data = data;
        bus2.proc2mem_size = size;  bus1.proc2mem_size = size;
    endtask

    // Drive one request for one cycle on instance d, check the combinational
    // response and queue whatever must come back.
    task automatic applyStimulus(input int d, input logic [1:0] cmd, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [1:0] size);
        logic        acc;
        logic [3:0]  obs_resp;
        int          key;
        exp_t        e;
        @(posedge clk);
        #1;
        set_bus(d, cmd, addr, data, size);
        #1;
        acc      = model_accept(cmd, addr, size);
        obs_resp = (d == D_L2) ? bus2.mem2proc_response : bus1.mem2proc_response;
        checkOutput((d == D_L2) ? "resp_l2" : "resp_l1", {28'd0, obs_resp},
                    {28'd0, acc ? tag_m[d] : 4'd0});
        key = d * 65536 + int'(addr[ADDR_BITS+1:2]);
        if (acc) begin
            e.due = cyc + lat_m[d];
            e.tag = tag_m[d];
            if (cmd == LOAD) begin
                e.data = model.exists(key) ? model[key] : 32'hxxxxxxxx;
            end else begin
                e.data = 32'd0;
                model[key] = merge(model.exists(key) ? model[key] : 32'd0, data, addr, size);
            end
            exp_q[d].push_back(e);
            tag_m[d] = (tag_m[d] == 4'd15) ? 4'd1 : tag_m[d] + 4'd1;
        end else if (cmd != NONE) begin
            err_q[d].push_back(cyc + 1);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(D_L2, NONE, 32'd0, 32'd0, SZ_W);
    endtask

    // One-cycle reset with a valid LOAD presented to both instances.
    task automatic doReset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus2.proc2mem_command = LOAD; bus1.proc2mem_command = LOAD;
        bus2.proc2mem_addr = 32'h10;  bus1.proc2mem_addr = 32'h10;
        bus2.proc2mem_size = SZ_W;    bus1.proc2mem_size = SZ_W;
        #1;
        checkOutput("resp_in_rst_l2", {28'd0, bus2.mem2proc_response}, 32'd0);
        checkOutput("resp_in_rst_l1", {28'd0, bus1.mem2proc_response}, 32'd0);
        for (int d = 0; d < 2; d++) begin
            exp_q[d].delete();
            err_q[d].delete();
            tag_m[d] = 4'd1;
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_bus(D_L2, NONE, 32'd0, 32'd0, SZ_W);
    endtask

    // Every cycle: tag, data and error of both instances against the queues.
    always @(negedge clk) begin
        exp_t        e;
        logic [3:0]  et;
        logic [31:0] ed;
        logic        ee;
        for (int d = 0; d < 2; d++) begin
            et = 4'd0; ed = 32'd0; ee = 1'b0;
            if (exp_q[d].size() > 0 && exp_q[d][0].due == cyc) begin
                e  = exp_q[d].pop_front();
                et = e.tag;
                ed = e.data;
            end
            if (err_q[d].size() > 0 && err_q[d][0] == cyc) begin
                void'(err_q[d].pop_front());
                ee = 1'b1;
            end
            if (d == D_L2) begin
                checkOutput("tag_l2",  {28'd0, bus2.mem2proc_tag}, {28'd0, et});
                checkOutput("data_l2", bus2.mem2proc_data, ed);
                checkOutput("err_l2",  {31'd0, bus2.mem_error}, {31'd0, ee});
            end else begin
                checkOutput("tag_l1",  {28'd0, bus1.mem2proc_tag}, {28'd0, et});
                checkOutput("data_l1", bus1.mem2proc_data, ed);
                checkOutput("err_l1",  {31'd0, bus1.mem_error}, {31'd0, ee});
            end
        end
    end

    initial begin
        tag_m[0] = 4'd1; tag_m[1] = 4'd1;
        lat_m[0] = 2;    lat_m[1] = 1;
        set_bus(D_L2, NONE, 32'd0, 32'd0, SZ_W);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Store then back-to-back load of the same word.
        applyStimulus(D_L2, STORE, 32'h10, 32'hDEADBEEF, SZ_W);
        applyStimulus(D_L2, LOAD,  32'h10, 32'd0,        SZ_W);

        // Byte and half stores merge into an existing word.
        applyStimulus(D_L2, STORE, 32'h20, 32'h11223344, SZ_W);
        applyStimulus(D_L2, STORE, 32'h22, 32'h123456AA, SZ_B);
        applyStimulus(D_L2, STORE, 32'h20, 32'h5555BEEF, SZ_H);
        applyStimulus(D_L2, LOAD,  32'h20, 32'd0,        SZ_W);
        applyStimulus(D_L2, STORE, 32'h0,  32'h0BADF00D, SZ_W);
        applyStimulus(D_L2, STORE, 32'h3FFC, 32'hA5A5A5A5, SZ_W);
        applyStimulus(D_L2, LOAD,  32'h3FFC, 32'd0,      SZ_W);
        idle(3);

        // Sixteen back-to-back loads from a fresh tag counter.
        doReset();
        for (int i = 0; i < 16; i++) begin
            applyStimulus(D_L2, LOAD, (i % 2 == 0) ? 32'h10 : 32'h20, 32'd0, SZ_W);
        end
        idle(3);

        // Rejected requests, then confirm the array was left alone.
        applyStimulus(D_L2, STORE, 32'h12,   32'hFFFFFFFF, SZ_W);
        applyStimulus(D_L2, LOAD,  32'h3,    32'd0,        SZ_H);
        applyStimulus(D_L2, RSVD,  32'h10,   32'hFFFFFFFF, SZ_W);
        applyStimulus(D_L2, LOAD,  32'h4000, 32'd0,        SZ_W);
        applyStimulus(D_L2, STORE, 32'h10,   32'hFFFFFFFF, 2'h3);
        idle(1);
        applyStimulus(D_L2, LOAD,  32'h10,   32'd0,        SZ_W);
        applyStimulus(D_L2, LOAD,  32'h0,    32'd0,        SZ_W);
        applyStimulus(D_L2, LOAD,  32'h2,    32'd0,        SZ_H);
        idle(3);

        // Reset with two loads in flight.
        applyStimulus(D_L2, LOAD, 32'h10, 32'd0, SZ_W);
        applyStimulus(D_L2, LOAD, 32'h20, 32'd0, SZ_W);
        doReset();
        applyStimulus(D_L2, LOAD, 32'h10, 32'd0, SZ_W);
        idle(3);

        // LATENCY=1 instance: LOAD / NONE / LOAD after a reset.
        applyStimulus(D_L1, STORE, 32'h40, 32'hCAFEF00D, SZ_W);
        idle(2);
        doReset();
        applyStimulus(D_L1, LOAD, 32'h40, 32'd0, SZ_W);
        applyStimulus(D_L1, NONE, 32'h40, 32'd0, SZ_W);
        applyStimulus(D_L1, LOAD, 32'h40, 32'd0, SZ_W);
        applyStimulus(D_L1, STORE, 32'h41, 32'h000000EE, SZ_B);
        applyStimulus(D_L1, LOAD, 32'h40, 32'd0, SZ_W);
        idle(4);

        checkOutput("drain_l2", 32'(exp_q[0].size() + err_q[0].size()), 32'd0);
        checkOutput("drain_l1", 32'(exp_q[1].size() + err_q[1].size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
